rails_tx: RTL and testbench

- Frame transmitter for the rails stack-permutation checker interface.
- A host loads one frame into a local 16x4 buffer: entry 0 is the train count N, entries 1..N are the departure order.
- On start, the block validates the frame and drives it nibble-by-nibble onto the checker's data bus. It then idles the bus at 0 and waits for the checker's valid/result verdict.
- It reports completion, pass/fail, timeout and frame error. The block is used as the on-chip driver and self-test source for the checker.

---
 rtl/rails_tx_if.sv | 26 ++
 rtl/rails_tx.sv | 128 ++++++++++++
 tb/tb_rails_tx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rails_tx_if.sv
// Host/checker signal bundle for the rails frame transmitter.
// The master side is the host plus checker; the slave side is rails_tx.
interface rails_tx_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       start;
    logic       busy;
    logic [3:0] data;
    logic       valid;
    logic       result;
    logic       done;
    logic       pass;
    logic       timeout;
    logic       err;

    modport master (
        output wr_en, wr_addr, wr_data, start, valid, result,
        input  busy, data, done, pass, timeout, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, valid, result,
        output busy, data, done, pass, timeout, err
    );
endinterface

// File: rtl/rails_tx.sv
// Frame transmitter for the rails stack-permutation checker: buffers one frame,
// validates it, streams it as nibbles and collects the checker's verdict.
module rails_tx #(
    parameter int MAX_N   = 10,
    parameter int TIMEOUT = 64
) (
    input  logic      clk,
    input  logic      reset,
    rails_tx_if.slave bus
);
    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t        r_state;
    logic [3:0]    r_buf [16];
    logic [3:0]    r_idx;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_data;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic          r_timeout;
    logic          r_err;
    logic          w_bad;

    // A frame is rejected if its count is out of range or any listed train
    // number is zero or larger than the count; entries past N are don't-care.
    always_comb begin
        w_bad = (r_buf[0] == 4'd0) || (int'(r_buf[0]) > MAX_N);
        for (int i = 1; i < 16; i++) begin
            if ((i <= int'(r_buf[0])) && ((r_buf[i] == 4'd0) || (r_buf[i] > r_buf[0]))) begin
                w_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_timer   <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.wr_en) begin
                        r_buf[bus.wr_addr] <= bus.wr_data;
                    end
                    if (bus.start) begin
                        r_state   <= CHECK;
                        r_busy    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                CHECK: begin
                    if (w_bad) begin
                        r_state <= DONE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= SEND;
                        r_idx   <= '0;
                    end
                end
                // The data register lags the state by one cycle, so the last
                // nibble is still on the bus during the first WAIT cycle.
                SEND: begin
                    r_data <= r_buf[r_idx];
                    r_idx  <= r_idx + 4'd1;
                    if (r_idx == r_buf[0]) begin
                        r_state <= WAIT;
                        r_timer <= '0;
                    end
                end
                WAIT: begin
                    r_data <= '0;
                    if (bus.valid) begin
                        r_pass  <= bus.result;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_timer == TIMER_LAST) begin
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.data    = r_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.pass    = r_pass;
    assign bus.timeout = r_timeout;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_rails_tx.sv
// Scoreboard bench for rails_tx: a frame-level model queues expected nibbles and
// verdicts when a start is issued, and a negedge monitor checks them as they appear.
module tb_rails_tx;
    localparam int MAX_N = 10;
    localparam int TO    = 16;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } nib_t;

    typedef struct {
        int         cyc;
        logic [2:0] flags;
    } res_t;

    logic       clk;
    logic       reset;
    int         cyc;
    int         vectors;
    int         miscompares;
    bit         monEn;
    bit         expBusy;
    logic [2:0] expFlags;
    logic [3:0] bm [16];
    nib_t       nibQ [$];
    res_t       resQ [$];

    rails_tx_if bus ();

    rails_tx #(
        .MAX_N  (MAX_N),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Frame rule straight from the checker interface definition.
    function automatic bit frameBad();
        int n;
        n = int'(bm[0]);
        if (n == 0 || n > MAX_N) return 1'b1;
        for (int i = 1; i <= n; i++) begin
            if (bm[i] == 4'd0 || int'(bm[i]) > n) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput();
        nib_t n;
        res_t r;
        if (nibQ.size() > 0 && nibQ[0].cyc == cyc) begin
            n = nibQ.pop_front();
            cmp("data_nibble", 8'(bus.data), 8'(n.val));
        end else begin
            cmp("data_idle", 8'(bus.data), 8'h0);
        end
        if (resQ.size() > 0 && resQ[0].cyc == cyc) begin
            r = resQ.pop_front();
            expBusy  = 1'b0;
            expFlags = r.flags;
            cmp("done_pulse", 8'(bus.done), 8'h1);
        end else begin
            cmp("done_quiet", 8'(bus.done), 8'h0);
        end
        cmp("busy", 8'(bus.busy), 8'(expBusy));
        cmp("pass_timeout_err", 8'({bus.pass, bus.timeout, bus.err}), 8'(expFlags));
    endtask

    always @(negedge clk) if (monEn) checkOutput();

    // All driving tasks start and end #1 after a rising edge.
    task automatic writeBuf(input logic [3:0] addr, input logic [3:0] val);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = val;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        bm[addr]  = val;
    endtask

    // ents holds entries 1..n, entry 1 in the least significant nibble.
    task automatic loadFrame(input logic [3:0] n, input logic [47:0] ents);
        writeBuf(4'd0, n);
        for (int i = 0; i < int'(n); i++) begin
            writeBuf(4'(i + 1), ents[4*i +: 4]);
        end
    endtask

    // vOff: verdict sampled vOff edges after the last nibble (0 = never);
    // rstEdge: reset sampled that many edges after start (0 = none).
    task automatic applyStimulus(input int vOff, input bit res, input bit busyWr,
                                 input int rstEdge, input bit coWr,
                                 input logic [3:0] coAddr, input logic [3:0] coData);
        int T, N, E, D, a;
        bit bad;
        logic [2:0] fl;
        bus.start = 1'b1;
        if (coWr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = coAddr;
            bus.wr_data = coData;
            bm[coAddr]  = coData;
        end
        T   = cyc + 1;
        N   = int'(bm[0]);
        bad = frameBad();
        E   = T + 2 + N;
        if (bad) begin
            D  = T + 1;
            fl = 3'b001;
        end else begin
            for (int i = 0; i <= N; i++) nibQ.push_back('{T + 2 + i, bm[i]});
            if (vOff >= 1 && vOff <= TO) begin
                D  = E + vOff;
                fl = {res, 2'b00};
            end else begin
                D  = E + TO;
                fl = 3'b010;
            end
        end
        resQ.push_back('{D, fl});
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        expBusy   = 1'b1;
        expFlags  = 3'b000;
        for (int k = T + 1; k <= D + 1; k++) begin
            bus.valid  = 1'b0;
            bus.result = res;
            if (!bad && vOff >= 1 && k == E + vOff) bus.valid = 1'b1;
            if (!bad && k == T + 3) begin
                bus.valid  = 1'b1;
                bus.result = ~res;
            end
            if (busyWr && !bad && (k == T + 2 || k == E + 1)) begin
                a = $urandom_range(0, N);
                bus.wr_en   = 1'b1;
                bus.wr_addr = 4'(a);
                bus.wr_data = bm[a] ^ 4'h8;
            end
            if (rstEdge > 0 && k == T + rstEdge) reset = 1'b0;
            @(posedge clk); #1;
            bus.valid = 1'b0;
            bus.wr_en = 1'b0;
            if (rstEdge > 0 && k == T + rstEdge) begin
                nibQ.delete();
                resQ.delete();
                expBusy  = 1'b0;
                expFlags = 3'b000;
                for (int i = 0; i < 16; i++) bm[i] = 4'd0;
                reset = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        int         v;
        logic [47:0] ents;
        vectors     = 0;
        miscompares = 0;
        monEn       = 1'b0;
        expBusy     = 1'b0;
        expFlags    = 3'b000;
        for (int i = 0; i < 16; i++) bm[i] = 4'd0;
        reset       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 4'd0;
        bus.start   = 1'b0;
        bus.valid   = 1'b0;
        bus.result  = 1'b0;
        @(posedge clk); #1;
        monEn = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;

        loadFrame(4'd5, 48'h5_4_3_2_1);
        applyStimulus(3, 1'b1, 1'b0, 0, 1'b0, 4'd0, 4'd0);

        loadFrame(4'd5, 48'h3_2_1_4_5);
        applyStimulus(2, 1'b0, 1'b0, 0, 1'b0, 4'd0, 4'd0);
        applyStimulus(5, 1'b0, 1'b0, 0, 1'b0, 4'd0, 4'd0);

        loadFrame(4'd3, 48'h1_2_3);
        applyStimulus(0, 1'b1, 1'b0, 0, 1'b0, 4'd0, 4'd0);
        applyStimulus(TO, 1'b1, 1'b0, 0, 1'b0, 4'd0, 4'd0);

        loadFrame(4'd0, 48'h0);
        applyStimulus(2, 1'b1, 1'b0, 0, 1'b0, 4'd0, 4'd0);
        loadFrame(4'd11, 48'hB_A_9_8_7_6_5_4_3_2_1);
        applyStimulus(2, 1'b1, 1'b0, 0, 1'b0, 4'd0, 4'd0);
        loadFrame(4'd4, 48'h3_2_6_1);
        applyStimulus(2, 1'b1, 1'b0, 0, 1'b0, 4'd0, 4'd0);

        loadFrame(4'd5, 48'h5_4_3_2_1);
        applyStimulus(0, 1'b0, 1'b0, 5, 1'b0, 4'd0, 4'd0);
        applyStimulus(3, 1'b1, 1'b0, 0, 1'b0, 4'd0, 4'd0);

        loadFrame(4'd4, 48'h1_2_3_4);
        applyStimulus(4, 1'b1, 1'b1, 0, 1'b0, 4'd0, 4'd0);
        applyStimulus(1, 1'b0, 1'b0, 0, 1'b0, 4'd0, 4'd0);
        writeBuf(4'd0, 4'd1);
        writeBuf(4'd1, 4'd1);
        applyStimulus(2, 1'b1, 1'b0, 0, 1'b0, 4'd0, 4'd0);

        // Count rewritten in the same cycle as start must be the one used.
        loadFrame(4'd2, 48'h3_2_1);
        applyStimulus(3, 1'b1, 1'b0, 0, 1'b1, 4'd0, 4'd3);

        for (int t = 0; t < 24; t++) begin
            if (t == 0 || $urandom_range(0, 3) != 0) begin
                n    = $urandom_range(0, 12);
                ents = '0;
                for (int i = 0; i < n; i++) begin
                    v = $urandom_range(1, n);
                    if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 15);
                    ents[4*i +: 4] = 4'(v);
                end
                loadFrame(4'(n), ents);
            end
            applyStimulus($urandom_range(0, 18), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 0, 1'b0, 4'd0, 4'd0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
